// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the round-robin arbitrating multiplexer.
package arb_mux_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_NUM_IN = 4;

  // Number of bits needed to hold an index in the range 0..value-1.
  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 32'sd1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational requester picker for arb_mux_rr.
// With ARB_MUX_RR_EN defined the search starts at ptr and wraps upward;
// without it the search always starts at channel 0 (fixed priority) and ptr
// is ignored.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter  int NUM_IN = DEF_NUM_IN,
  localparam int SEL_W  = clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              grant_any
);

  logic [SEL_W-1:0] start_s;
  int               cand_s;

`ifdef ARB_MUX_RR_EN
  assign start_s = ptr;
`else
  logic unused_ptr_s;
  assign start_s      = {SEL_W{1'b0}};
  assign unused_ptr_s = ^ptr;
`endif

  // Scan requesters starting at start_s, wrapping modulo NUM_IN; first hit wins.
  always_comb begin
    grant     = {NUM_IN{1'b0}};
    grant_idx = {SEL_W{1'b0}};
    grant_any = 1'b0;
    cand_s    = 32'sd0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand_s = int'(start_s) + k;
      if (cand_s >= NUM_IN) begin
        cand_s = cand_s - NUM_IN;
      end else begin
        cand_s = cand_s;
      end
      if (!grant_any && req[cand_s[SEL_W-1:0]]) begin
        grant_any                 = 1'b1;
        grant[cand_s[SEL_W-1:0]]  = 1'b1;
        grant_idx                 = cand_s[SEL_W-1:0];
      end else begin
        grant_any = grant_any;
      end
    end
  end

endmodule

// File: rtl/arb_mux_rr.sv
// N-input registered arbitrating multiplexer with valid/ready on every port.
// One requester is granted per cycle and captured into a one-entry output
// register that holds until the consumer accepts it.
// Build option: define ARB_MUX_RR_EN for round-robin arbitration; left
// undefined the pointer register is removed and the lowest valid index wins.
module arb_mux_rr
  import arb_mux_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int NUM_IN = DEF_NUM_IN,
  localparam int SEL_W  = clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  input  logic                    out_ready
);

  logic              out_valid_r;
  logic [WIDTH-1:0]  out_data_r;
  logic [SEL_W-1:0]  out_src_r;
  logic [SEL_W-1:0]  ptr_s;
  logic [NUM_IN-1:0] grant_s;
  logic [SEL_W-1:0]  grant_idx_s;
  logic              grant_any_s;
  logic              load_s;
  logic [WIDTH-1:0]  sel_data_s;

  rr_arbiter #(
    .NUM_IN (NUM_IN)
  ) u_arbiter (
    .req       (in_valid),
    .ptr       (ptr_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  // Register can take a word when empty or being drained this cycle.
  assign load_s = !out_valid_r || out_ready;

  // Accept only the granted channel, and nothing while reset is held.
  always_comb begin
    in_ready = {NUM_IN{1'b0}};
    if (!rst && load_s) begin
      in_ready = grant_s;
    end else begin
      in_ready = {NUM_IN{1'b0}};
    end
  end

  // One-hot data select of the granted channel.
  always_comb begin
    sel_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_s[i]) begin
        sel_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

`ifdef ARB_MUX_RR_EN
  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] ptr_next_s;

  // Pointer moves to the channel after the winner, wrapping at NUM_IN-1.
  always_comb begin
    ptr_next_s = {SEL_W{1'b0}};
    if (grant_idx_s == SEL_W'(NUM_IN - 1)) begin
      ptr_next_s = {SEL_W{1'b0}};
    end else begin
      ptr_next_s = grant_idx_s + {{(SEL_W-1){1'b0}}, 1'b1};
    end
  end

  // Round-robin pointer; advances only when a word is actually accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= {SEL_W{1'b0}};
    end else if (load_s && grant_any_s) begin
      ptr_r <= ptr_next_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr_s = ptr_r;
`else
  assign ptr_s = {SEL_W{1'b0}};
`endif

  // Output register: capture on accept, empty on idle load, hold on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_src_r   <= {SEL_W{1'b0}};
    end else if (load_s) begin
      if (grant_any_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= sel_data_s;
        out_src_r   <= grant_idx_s;
      end else begin
        out_valid_r <= 1'b0;
        out_data_r  <= out_data_r;
        out_src_r   <= out_src_r;
      end
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_src_r   <= out_src_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_src   = out_src_r;

endmodule

// File: tb/tb_arb_mux_rr.sv
// Directed bench for arb_mux_rr (WIDTH=16, NUM_IN=4) with a reference model
// and a scoreboard queue of accepted words. Follows ARB_MUX_RR_EN for the
// expected arbitration policy.
module tb_arb_mux_rr;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [63:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_src;
  logic        out_ready;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  src;
  } word_t;

  word_t sb[$];
  logic  m_valid;
  int    m_ptr;
  int    checks;
  int    failures;

  arb_mux_rr #(
    .WIDTH  (16),
    .NUM_IN (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, check at negedge against the model, advance model.
  task automatic step(input logic [3:0] v, input logic r, input logic [15:0] base);
    int          g;
    int          c;
    logic        mload;
    logic [3:0]  exp_ready;
    word_t       w;
    in_valid  = v;
    out_ready = r;
    for (int i = 0; i < 4; i++) in_data[i*16 +: 16] = base + 16'(i);
    @(negedge clk);
    g = -1;
    for (int k = 0; k < 4; k++) begin
      c = (m_ptr + k) % 4;
      if (g < 0 && v[c]) g = c;
    end
    mload = !m_valid || r;
    exp_ready = (mload && g >= 0) ? 4'(4'b0001 << g) : 4'b0000;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        check("out_data", 32'(out_data), 32'(sb[0].data));
        check("out_src", 32'(out_src), 32'(sb[0].src));
        if (r) void'(sb.pop_front());
      end
    end
    if (mload) begin
      if (g >= 0) begin
        w.data = base + 16'(g);
        w.src  = 2'(g);
        sb.push_back(w);
        m_valid = 1'b1;
`ifdef ARB_MUX_RR_EN
        m_ptr = (g + 1) % 4;
`else
        m_ptr = 0;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    m_valid   = 1'b0;
    m_ptr     = 0;
    rst       = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    in_data   = 64'h0;

    // Reset held with every channel requesting.
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_src", 32'(out_src), 32'd0);
    @(posedge clk);
    #1;
    check("rst_in_ready_edge", 32'(in_ready), 32'd0);
    check("rst_out_valid_edge", 32'(out_valid), 32'd0);
    rst = 1'b0;

    // Rotation with all channels valid.
    for (int n = 0; n < 6; n++) step(4'b1111, 1'b1, 16'hA0A0);

    // Backpressure for three cycles, then release.
    for (int n = 0; n < 3; n++) step(4'b1111, 1'b0, 16'hB0B0);
    step(4'b1111, 1'b1, 16'hB0B0);
    step(4'b1111, 1'b1, 16'hB1B0);

    // Empty drain.
    step(4'b0000, 1'b1, 16'hB2B0);
    step(4'b0000, 1'b1, 16'hB2B0);

    // Sparse requests with pointer wrap.
    step(4'b0100, 1'b1, 16'hC0C0);
    for (int n = 0; n < 3; n++) step(4'b0101, 1'b1, 16'hC1C0 + 16'(n * 16));
    step(4'b0000, 1'b1, 16'hC0C0);

    // Channels 1 and 3 only.
    for (int n = 0; n < 4; n++) step(4'b1010, 1'b1, 16'hD0D0);
    step(4'b0000, 1'b1, 16'hD0D0);

    // Pseudo-random traffic and stalls.
    for (int n = 0; n < 24; n++)
      step(4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 16'($urandom));

    // Asynchronous reset while a word is held.
    step(4'b1111, 1'b1, 16'hE0E0);
    step(4'b1111, 1'b0, 16'hE1E0);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_out_src", 32'(out_src), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    m_valid = 1'b0;
    m_ptr   = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(4'b1111, 1'b1, 16'hF0F0);
    step(4'b1111, 1'b1, 16'hF1F0);
    step(4'b0000, 1'b1, 16'hF2F0);
    step(4'b0000, 1'b1, 16'hF2F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
